// File: rtl/fft_frame_ctrl.sv
// Frames samples into an R2SDF FFT pipeline, zero-pads a starved frame, bounds frames in flight,
// and tags pipeline output with natural-order bin plus sof/eof; every output is registered (1 cycle).
module fft_frame_ctrl #(
  parameter int N_LOG2       = 6,
  parameter int DATA_W       = 16,
  parameter int OUT_W        = 37,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iIn_valid,
  input  logic [DATA_W-1:0] iIn_Re,
  input  logic [DATA_W-1:0] iIn_Im,
  output logic              oIn_ready,
  output logic              oFft_valid,
  output logic [DATA_W-1:0] oFft_Re,
  output logic [DATA_W-1:0] oFft_Im,
  input  logic              iFft_valid,
  input  logic [OUT_W-1:0]  iFft_Re,
  input  logic [OUT_W-1:0]  iFft_Im,
  output logic              oOut_valid,
  output logic [OUT_W-1:0]  oOut_Re,
  output logic [OUT_W-1:0]  oOut_Im,
  output logic [N_LOG2-1:0] oOut_index,
  output logic              oOut_sof,
  output logic              oOut_eof,
  input  logic              iClr_err,
  output logic              oUnderrun,
  output logic              oBusy
);

  localparam int FL_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAD} state_t;

  state_t              r_state;
  logic [N_LOG2-1:0]   r_in_cnt;
  logic [N_LOG2-1:0]   r_out_cnt;
  logic [FL_W-1:0]     r_fl_cnt;
  logic                r_in_rdy;
  logic                r_underrun;
  logic                r_fft_vld;
  logic [DATA_W-1:0]   r_fft_re;
  logic [DATA_W-1:0]   r_fft_im;
  logic                r_out_vld;
  logic [OUT_W-1:0]    r_out_re;
  logic [OUT_W-1:0]    r_out_im;
  logic [N_LOG2-1:0]   r_out_idx;
  logic                r_out_sof;
  logic                r_out_eof;

  logic                w_accept;
  logic                w_fl_inc;
  logic                w_fl_dec;
  logic                w_in_last;
  logic                w_out_last;
  logic                w_fl_room_nxt;
  logic [FL_W-1:0]     w_fl_nxt;
  logic [N_LOG2-1:0]   w_out_idx;

  assign w_accept   = iIn_valid & r_in_rdy;
  assign w_fl_inc   = w_accept & (r_state == S_IDLE);
  assign w_in_last  = (r_in_cnt == {N_LOG2{1'b1}});
  assign w_out_last = (r_out_cnt == {N_LOG2{1'b1}});
  // Output with nothing in flight still streams through, it just cannot underflow the count.
  assign w_fl_dec   = iFft_valid & w_out_last & (r_fl_cnt != '0);

  always_comb begin
    w_fl_nxt = r_fl_cnt;
    if (w_fl_inc && !w_fl_dec) begin
      w_fl_nxt = r_fl_cnt + FL_W'(1);
    end else if (!w_fl_inc && w_fl_dec) begin
      w_fl_nxt = r_fl_cnt - FL_W'(1);
    end
  end

  assign w_fl_room_nxt = (w_fl_nxt < FL_W'(MAX_INFLIGHT));

  always_comb begin
    w_out_idx = '0;
    for (int b = 0; b < N_LOG2; b++) begin
      w_out_idx[b] = r_out_cnt[N_LOG2-1-b];
    end
  end

  // Ready is registered, so it is computed from the state and in-flight count being entered.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_in_cnt   <= '0;
      r_fl_cnt   <= '0;
      r_in_rdy   <= 1'b0;
      r_underrun <= 1'b0;
      r_fft_vld  <= 1'b0;
      r_fft_re   <= '0;
      r_fft_im   <= '0;
    end else begin
      r_fl_cnt  <= w_fl_nxt;
      r_fft_vld <= 1'b0;
      r_fft_re  <= '0;
      r_fft_im  <= '0;
      if (iClr_err) begin
        r_underrun <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_in_rdy <= w_fl_room_nxt;
          if (w_accept) begin
            r_state   <= S_RUN;
            r_in_cnt  <= N_LOG2'(1);
            r_in_rdy  <= 1'b1;
            r_fft_vld <= 1'b1;
            r_fft_re  <= iIn_Re;
            r_fft_im  <= iIn_Im;
          end
        end
        S_RUN: begin
          r_fft_vld <= 1'b1;
          r_in_cnt  <= r_in_cnt + N_LOG2'(1);
          if (iIn_valid) begin
            r_fft_re <= iIn_Re;
            r_fft_im <= iIn_Im;
          end else begin
            r_underrun <= 1'b1;
          end
          if (w_in_last) begin
            r_state  <= S_IDLE;
            r_in_rdy <= w_fl_room_nxt;
          end else if (!iIn_valid) begin
            r_state  <= S_PAD;
            r_in_rdy <= 1'b0;
          end else begin
            r_in_rdy <= 1'b1;
          end
        end
        S_PAD: begin
          r_fft_vld <= 1'b1;
          r_in_cnt  <= r_in_cnt + N_LOG2'(1);
          if (w_in_last) begin
            r_state  <= S_IDLE;
            r_in_rdy <= w_fl_room_nxt;
          end else begin
            r_in_rdy <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_in_rdy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_out_cnt <= '0;
      r_out_vld <= 1'b0;
      r_out_re  <= '0;
      r_out_im  <= '0;
      r_out_idx <= '0;
      r_out_sof <= 1'b0;
      r_out_eof <= 1'b0;
    end else begin
      r_out_vld <= iFft_valid;
      r_out_re  <= iFft_valid ? iFft_Re : '0;
      r_out_im  <= iFft_valid ? iFft_Im : '0;
      r_out_idx <= iFft_valid ? w_out_idx : '0;
      r_out_sof <= iFft_valid & (r_out_cnt == '0);
      r_out_eof <= iFft_valid & w_out_last;
      if (iFft_valid) begin
        r_out_cnt <= r_out_cnt + N_LOG2'(1);
      end
    end
  end

  assign oIn_ready  = r_in_rdy;
  assign oFft_valid = r_fft_vld;
  assign oFft_Re    = r_fft_re;
  assign oFft_Im    = r_fft_im;
  assign oOut_valid = r_out_vld;
  assign oOut_Re    = r_out_re;
  assign oOut_Im    = r_out_im;
  assign oOut_index = r_out_idx;
  assign oOut_sof   = r_out_sof;
  assign oOut_eof   = r_out_eof;
  assign oUnderrun  = r_underrun;
  assign oBusy      = (r_state != S_IDLE) | (r_fl_cnt != '0);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: directed scenarios plus a randomized run against a frame-level model.
module tb_fft_frame_ctrl;

  localparam int NL   = 6;
  localparam int N    = 64;
  localparam int DW   = 16;
  localparam int OW   = 37;
  localparam int MAXF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld, in_rdy;
  logic [DW-1:0] in_re, in_im;
  logic          fft_vld;
  logic [DW-1:0] fft_re, fft_im;
  logic          pf_vld;
  logic [OW-1:0] pf_re, pf_im;
  logic          out_vld, out_sof, out_eof;
  logic [OW-1:0] out_re, out_im;
  logic [NL-1:0] out_idx;
  logic          clr_err, underrun, busy;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.N_LOG2(NL), .DATA_W(DW), .OUT_W(OW), .MAX_INFLIGHT(MAXF)) dut (
    .iClk(clk), .iRst(rst),
    .iIn_valid(in_vld), .iIn_Re(in_re), .iIn_Im(in_im), .oIn_ready(in_rdy),
    .oFft_valid(fft_vld), .oFft_Re(fft_re), .oFft_Im(fft_im),
    .iFft_valid(pf_vld), .iFft_Re(pf_re), .iFft_Im(pf_im),
    .oOut_valid(out_vld), .oOut_Re(out_re), .oOut_Im(out_im), .oOut_index(out_idx),
    .oOut_sof(out_sof), .oOut_eof(out_eof),
    .iClr_err(clr_err), .oUnderrun(underrun), .oBusy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: position within the current input frame (0 = no frame open),
  // whether the frame is being padded, frames in flight, and output sample position.
  int m_pos, m_fl, m_oc;
  bit m_pad, m_und, m_rdy;

  logic          exp_rdy, exp_fft_vld, exp_out_vld, exp_sof, exp_eof, exp_und, exp_busy;
  logic [DW-1:0] exp_fft_re, exp_fft_im;
  logic [OW-1:0] exp_out_re, exp_out_im;
  logic [NL-1:0] exp_idx;

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < NL; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  // One clock: drive inputs at the falling edge, advance the model, return at the next falling edge.
  task automatic cyc(input bit r, input bit v, input bit c, input bit fv);
    logic [63:0] t;
    bit acc, start_pad, iss, inc, dec;
    rst = r; in_vld = v; clr_err = c; pf_vld = fv;
    in_re = DW'($urandom); in_im = DW'($urandom);
    t = {$urandom, $urandom}; pf_re = t[OW-1:0];
    t = {$urandom, $urandom}; pf_im = t[OW-1:0];
    if (r) begin
      m_pos = 0; m_fl = 0; m_oc = 0; m_pad = 0; m_und = 0; m_rdy = 0;
      exp_fft_vld = 0; exp_fft_re = '0; exp_fft_im = '0;
      exp_out_vld = 0; exp_out_re = '0; exp_out_im = '0;
      exp_idx = '0; exp_sof = 0; exp_eof = 0;
    end else begin
      acc       = v && m_rdy;
      start_pad = (m_pos > 0) && !m_pad && !v;
      iss       = acc || m_pad || start_pad;
      inc       = acc && (m_pos == 0);
      dec       = fv && (m_oc == N - 1) && (m_fl > 0);
      if (start_pad) m_und = 1;
      else if (c) m_und = 0;
      if (start_pad) m_pad = 1;
      if (iss) begin
        m_pos++;
        if (m_pos == N) begin m_pos = 0; m_pad = 0; end
      end
      m_fl = m_fl + int'(inc) - int'(dec);
      exp_fft_vld = iss;
      exp_fft_re  = acc ? in_re : '0;
      exp_fft_im  = acc ? in_im : '0;
      exp_out_vld = fv;
      exp_out_re  = fv ? pf_re : '0;
      exp_out_im  = fv ? pf_im : '0;
      exp_idx     = fv ? NL'(brev(m_oc)) : '0;
      exp_sof     = fv && (m_oc == 0);
      exp_eof     = fv && (m_oc == N - 1);
      if (fv) m_oc = (m_oc + 1) % N;
      m_rdy = ((m_pos > 0) && !m_pad) || ((m_pos == 0) && (m_fl < MAXF));
    end
    exp_rdy  = m_rdy;
    exp_und  = m_und;
    exp_busy = (m_pos > 0) || (m_fl > 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 0);
    n_checks++; if (in_rdy !== 1'b0)   begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", in_rdy); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%0b exp=0", underrun); end
    n_checks++; if (fft_vld !== 1'b0 || fft_re !== '0) begin n_fail++; $display("FAIL reset_fft got=%0b/%0h exp=0/0", fft_vld, fft_re); end
    n_checks++; if (out_vld !== 1'b0 || out_idx !== '0) begin n_fail++; $display("FAIL reset_out got=%0b/%0h exp=0/0", out_vld, out_idx); end
    cyc(0, 0, 0, 0);
    n_checks++; if (in_rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_release_ready got=%0b exp=1", in_rdy); end
  endtask

  task automatic test_full_frame();
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      if (in_rdy !== 1'b1) bad++;
      cyc(0, 1, 0, 0);
      if (fft_vld !== 1'b1 || fft_re !== in_re || fft_im !== in_im) bad++;
    end
    n_checks++; if (bad != 0)          begin n_fail++; $display("FAIL frame_issue bad_cycles=%0d exp=0", bad); end
    n_checks++; if (in_rdy !== 1'b1)   begin n_fail++; $display("FAIL frame_end_ready got=%0b exp=1", in_rdy); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL frame_end_busy got=%0b exp=1", busy); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL frame_underrun got=%0b exp=0", underrun); end
    cyc(0, 0, 0, 0);
    n_checks++; if (fft_vld !== 1'b0 || fft_re !== '0) begin n_fail++; $display("FAIL frame_idle_fft got=%0b/%0h exp=0/0", fft_vld, fft_re); end
  endtask

  task automatic test_out_index();
    int bad = 0;
    for (int k = 0; k < N; k++) begin
      cyc(0, 0, 0, 1);
      if (out_vld !== 1'b1 || out_re !== pf_re || out_im !== pf_im) bad++;
      if (out_idx !== NL'(brev(k))) begin
        bad++; $display("FAIL out_index k=%0d got=%0d exp=%0d", k, out_idx, brev(k));
      end
      if (out_sof !== (k == 0) || out_eof !== (k == N - 1)) bad++;
    end
    n_checks++; if (bad != 0)      begin n_fail++; $display("FAIL out_stream bad=%0d exp=0", bad); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL out_drained_busy got=%0b exp=0", busy); end
    cyc(0, 0, 0, 0);
    n_checks++; if (out_vld !== 1'b0 || out_re !== '0 || out_eof !== 1'b0) begin n_fail++; $display("FAIL out_idle got=%0b/%0h exp=0/0", out_vld, out_re); end
  endtask

  task automatic test_underrun();
    int low_rdy = 0, zeros = 0;
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 0, 0);
      if (in_rdy === 1'b0) low_rdy++;
      if (fft_vld === 1'b1 && fft_re === '0 && fft_im === '0) zeros++;
    end
    n_checks++; if (low_rdy != 53)     begin n_fail++; $display("FAIL underrun_ready_low got=%0d exp=53", low_rdy); end
    n_checks++; if (zeros != 54)       begin n_fail++; $display("FAIL underrun_pad_count got=%0d exp=54", zeros); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got=%0b exp=1", underrun); end
    cyc(0, 0, 1, 0);
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear got=%0b exp=0", underrun); end
    for (int k = 0; k < N; k++) cyc(0, 0, 0, 1);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL underrun_drain_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int blocked = 0, early = 0;
    for (int i = 0; i < 2 * N; i++) cyc(0, 1, 0, 0);
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked_ready got=%0b exp=0", in_rdy); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      if (fft_vld !== 1'b0) blocked++;
    end
    n_checks++; if (blocked != 0) begin n_fail++; $display("FAIL b2b_third_issued got=%0d exp=0", blocked); end
    for (int k = 0; k < N - 1; k++) begin
      cyc(0, 1, 0, 1);
      if (in_rdy !== 1'b0) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL b2b_early_ready got=%0d exp=0", early); end
    cyc(0, 1, 0, 1);
    n_checks++; if (out_eof !== 1'b1 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_eof_ready got=%0b/%0b exp=1/1", out_eof, in_rdy); end
    for (int i = 0; i < N; i++) cyc(0, 1, 0, 0);
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_frame3_full got=%0b exp=0", in_rdy); end
    for (int k = 0; k < N; k++) cyc(0, 0, 0, 1);
    for (int k = 0; k < N - 1; k++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    n_checks++; if (fft_vld !== 1'b1 || out_eof !== 1'b1) begin n_fail++; $display("FAIL simul_setup got=%0b/%0b exp=1/1", fft_vld, out_eof); end
    for (int i = 0; i < N - 1; i++) cyc(0, 1, 0, 0);
    n_checks++; if (in_rdy !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL simul_fl_one got=%0b/%0b exp=1/1", in_rdy, busy); end
    for (int i = 0; i < N; i++) cyc(0, 1, 0, 0);
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL simul_fl_two got=%0b exp=0", in_rdy); end
    for (int k = 0; k < 2 * N; k++) cyc(0, 0, 0, 1);
    n_checks++; if (busy !== 1'b0 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_drained got=%0b/%0b exp=0/1", busy, in_rdy); end
  endtask

  task automatic test_reset_midframe();
    int pads = 0;
    for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 1);
    n_checks++; if (in_rdy !== 1'b0 || fft_vld !== 1'b0 || fft_re !== '0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL midrst_in_side got=%0b/%0b/%0h/%0b exp=0/0/0/0", in_rdy, fft_vld, fft_re, busy); end
    n_checks++; if (out_vld !== 1'b0 || out_re !== '0 || out_idx !== '0 || out_sof !== 1'b0 || underrun !== 1'b0)
      begin n_fail++; $display("FAIL midrst_out_side got=%0b/%0h/%0h/%0b exp=0/0/0/0", out_vld, out_re, out_idx, underrun); end
    cyc(0, 0, 0, 0);
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%0b exp=1", in_rdy); end
    for (int i = 0; i < 70; i++) begin
      cyc(0, 0, 0, 0);
      if (fft_vld !== 1'b0) pads++;
    end
    n_checks++; if (pads != 0) begin n_fail++; $display("FAIL midrst_pad got=%0d exp=0", pads); end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 97,
          $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1);
      n_checks++; if (in_rdy !== exp_rdy)     begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", i, in_rdy, exp_rdy); end
      n_checks++; if (fft_vld !== exp_fft_vld) begin n_fail++; $display("FAIL rnd_fft_vld c=%0d got=%0b exp=%0b", i, fft_vld, exp_fft_vld); end
      n_checks++; if (fft_re !== exp_fft_re || fft_im !== exp_fft_im)
        begin n_fail++; $display("FAIL rnd_fft_dat c=%0d got=%0h/%0h exp=%0h/%0h", i, fft_re, fft_im, exp_fft_re, exp_fft_im); end
      n_checks++; if (out_vld !== exp_out_vld) begin n_fail++; $display("FAIL rnd_out_vld c=%0d got=%0b exp=%0b", i, out_vld, exp_out_vld); end
      n_checks++; if (out_re !== exp_out_re || out_im !== exp_out_im)
        begin n_fail++; $display("FAIL rnd_out_dat c=%0d got=%0h/%0h exp=%0h/%0h", i, out_re, out_im, exp_out_re, exp_out_im); end
      n_checks++; if (out_idx !== exp_idx)     begin n_fail++; $display("FAIL rnd_index c=%0d got=%0d exp=%0d", i, out_idx, exp_idx); end
      n_checks++; if (out_sof !== exp_sof || out_eof !== exp_eof)
        begin n_fail++; $display("FAIL rnd_sof_eof c=%0d got=%0b%0b exp=%0b%0b", i, out_sof, out_eof, exp_sof, exp_eof); end
      n_checks++; if (underrun !== exp_und)    begin n_fail++; $display("FAIL rnd_underrun c=%0d got=%0b exp=%0b", i, underrun, exp_und); end
      n_checks++; if (busy !== exp_busy)       begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", i, busy, exp_busy); end
    end
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_re = '0; in_im = '0;
    pf_vld = 1'b0; pf_re = '0; pf_im = '0; clr_err = 1'b0;
    m_pos = 0; m_fl = 0; m_oc = 0; m_pad = 0; m_und = 0; m_rdy = 0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_out_index();
    test_underrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter N_LOG2, default 6, log2 of FFT length N; N=64 drives the six-stage R2SDF pipeline.
REQ-002 Parameter DATA_W, default 16, width of the input sample Re/Im.
REQ-003 Parameter OUT_W, default 37, width of the pipeline output Re/Im.
REQ-004 Parameter MAX_INFLIGHT, default 2, maximum number of frames issued but not yet fully output.
REQ-005 iClk  in  1  single clock; all logic on rising edge.
REQ-006 iRst  in  1  reset; synchronous, active-high.
REQ-007 iIn_valid, iIn_Re, iIn_Im  in  1, DATA_W, DATA_W  source sample and its qualifier.
REQ-008 oIn_ready  out  1  sample accepted on cycles where iIn_valid & oIn_ready.
REQ-009 oFft_valid, oFft_Re, oFft_Im  out  1, DATA_W, DATA_W  sample stream to first pipeline stage.
REQ-010 iFft_valid, iFft_Re, iFft_Im  in  1, OUT_W, OUT_W  output stream of last pipeline stage.
REQ-011 oOut_valid, oOut_Re, oOut_Im  out  1, OUT_W, OUT_W  registered copy of pipeline output.
REQ-012 oOut_index  out  N_LOG2  natural-order frequency bin of the current oOut sample.
REQ-013 oOut_sof, oOut_eof  out  1 each  first / last output sample of a frame.
REQ-014 iClr_err  in  1  clears oUnderrun.
REQ-015 oUnderrun  out  1  sticky: a frame was zero-padded.
REQ-016 oBusy  out  1  high when FSM not IDLE or in-flight count nonzero.

Function
REQ-017 FSM states IDLE, RUN, PAD; input sample counter in_cnt (N_LOG2 bits); in-flight counter fl_cnt (0..MAX_INFLIGHT).
REQ-018 IDLE: oIn_ready = (fl_cnt < MAX_INFLIGHT); accept -> RUN, in_cnt=1, fl_cnt+1.
REQ-019 RUN: oIn_ready=1; each accepted sample in_cnt+1; iIn_valid=0 -> PAD, set oUnderrun, issue zero sample, in_cnt+1.
REQ-020 PAD: oIn_ready=0; each cycle issue zero sample (Re=Im=0), in_cnt+1; a frame is never stalled mid-way.
REQ-021 When sample N-1 (in_cnt wraps to 0) is issued from RUN or PAD -> IDLE.
REQ-022 oFft_valid/Re/Im are registered: one-cycle latency from acceptance or pad issue; oFft_valid=0 and data held at 0 otherwise.
REQ-023 Output counter out_cnt (N_LOG2 bits) advances on each iFft_valid, wraps N-1 -> 0; oOut_index = bit-reverse(out_cnt).
REQ-024 oOut_valid/Re/Im/index/sof/eof registered one cycle after iFft_valid; sof when out_cnt=0, eof when out_cnt=N-1; all zero when iFft_valid=0.
REQ-025 fl_cnt decrements on iFft_valid with out_cnt=N-1; simultaneous increment and decrement leaves fl_cnt unchanged.
REQ-026 fl_cnt never exceeds MAX_INFLIGHT nor underflows; iFft_valid with fl_cnt=0 is ignored for fl_cnt, but still passed through and counted in out_cnt.
REQ-027 oUnderrun set has priority over iClr_err in the same cycle.
REQ-028 Pipeline latency is not assumed; output framing derives only from iFft_valid.

Reset
REQ-029 While iRst=1 on a clock edge: FSM=IDLE, in_cnt=out_cnt=fl_cnt=0.
REQ-030 After that edge: every output 0, including oIn_ready, oUnderrun and oBusy.
REQ-031 oIn_ready rises the first cycle after iRst deasserts.
REQ-032 Reset mid-frame abandons the partial frame; no padding is issued after reset.

Verification
REQ-033 64 contiguous valid samples from IDLE -> 64 oFft_valid cycles each 1 cycle after accept, FSM back to IDLE, fl_cnt=1, oUnderrun=0.
REQ-034 iIn_valid drops at sample 10 -> samples 10..63 issued as zeros, oIn_ready=0 for 53 cycles, oUnderrun=1 until iClr_err pulse.
REQ-035 Three back-to-back frames, no iFft_valid -> third frame blocked (oIn_ready=0 in IDLE) with fl_cnt=2; first output eof -> oIn_ready=1 next cycle.
REQ-036 64 iFft_valid cycles -> oOut_index sequence 0,32,16,48,8,...,63; sof on first, eof on last, 1-cycle latency.
REQ-037 Frame acceptance and final output sample in same cycle at fl_cnt=1 -> fl_cnt stays 1.
REQ-038 iRst pulse at in_cnt=30 -> next cycle all outputs 0, oIn_ready=1 the cycle after release, no zero-pad samples issued.
